// File: rtl/line_fifo_pkg.sv
// Shared constants and helpers for the line packing/unpacking FIFOs.
package line_fifo_pkg;

    localparam int LINE_WIDTH_DEF = 32;
    localparam int WORD_WIDTH_DEF = 8;
    localparam int NUM_LINES_DEF  = 4;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_word_select.sv
// Combinational word mux: picks the idx-th WORD_WIDTH slice of a line, word 0 in the LSBs.
module line_word_select #(
    parameter int LINE_WIDTH = 32,
    parameter int WORD_WIDTH = 8,
    parameter int IDX_BITS   = 2
) (
    input  logic [LINE_WIDTH-1:0] line,
    input  logic [IDX_BITS-1:0]   idx,
    output logic [WORD_WIDTH-1:0] word
);

    assign word = line[int'(idx) * WORD_WIDTH +: WORD_WIDTH];

endmodule

// File: rtl/line_unpack_fifo.sv
// Line-in / word-out FIFO for the pixel pipeline; one registered word per accepted read.
// Define LINE_UNPACK_FIFO_STATUS_EN to add occupancy, overflow and underflow status ports.
module line_unpack_fifo
    import line_fifo_pkg::*;
#(
    parameter  int LINE_WIDTH     = LINE_WIDTH_DEF,
    parameter  int WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter  int NUM_LINES      = NUM_LINES_DEF,
    localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH,
    localparam int PTR_BITS       = clogb2(NUM_LINES),
    localparam int IDX_BITS       = clogb2(WORDS_PER_LINE)
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    input  logic [LINE_WIDTH-1:0] line_in,
    input  logic                  line_we,
    output logic                  full,
    input  logic                  rd,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    output logic                  last_word,
    output logic                  empty
`ifdef LINE_UNPACK_FIFO_STATUS_EN
    ,
    output logic [PTR_BITS:0]     occupancy,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [PTR_BITS:0]   PTR_ONE  = 1;
    localparam logic [IDX_BITS-1:0] IDX_ONE  = 1;
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(WORDS_PER_LINE - 1);

    logic [LINE_WIDTH-1:0] mem_q [NUM_LINES];

    logic [PTR_BITS:0]     head_q, head_d;
    logic [PTR_BITS:0]     base_q, base_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [WORD_WIDTH-1:0] word_out_q, word_out_d;
    logic                  word_valid_q, word_valid_d;
    logic                  last_word_q, last_word_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  idx_last;
    logic [WORD_WIDTH-1:0] sel_word;

    // Status flags come from registered pointers only, so same-cycle read/write see pre-edge state.
    assign full      = (head_q[PTR_BITS-1:0] == base_q[PTR_BITS-1:0]) &&
                       (head_q[PTR_BITS] != base_q[PTR_BITS]);
    assign empty     = (head_q == base_q);
    assign wr_accept = line_we && !full;
    assign rd_accept = rd && !empty;
    assign idx_last  = (idx_q == IDX_LAST);

    line_word_select #(
        .LINE_WIDTH (LINE_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_BITS   (IDX_BITS)
    ) u_word_select (
        .line (mem_q[base_q[PTR_BITS-1:0]]),
        .idx  (idx_q),
        .word (sel_word)
    );

    // NOTE: every _d gets a default before any branch; a path that leaves one unassigned infers a latch.
    always_comb begin
        head_d       = head_q;
        base_d       = base_q;
        idx_d        = idx_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        last_word_d  = 1'b0;

        if (wr_accept) begin
            head_d = head_q + PTR_ONE;
        end

        if (rd_accept) begin
            word_out_d   = sel_word;
            word_valid_d = 1'b1;
            last_word_d  = idx_last;
            if (idx_last) begin
                idx_d  = '0;
                base_d = base_q + PTR_ONE;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            head_q       <= '0;
            base_q       <= '0;
            idx_q        <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            last_word_q  <= 1'b0;
        end else begin
            head_q       <= head_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            last_word_q  <= last_word_d;
        end
    end

    // NOTE: line storage is deliberately not reset; a slot is never read before it is written.
    always_ff @(posedge pixel_clk) begin
        if (wr_accept) begin
            mem_q[head_q[PTR_BITS-1:0]] <= line_in;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign last_word  = last_word_q;

`ifdef LINE_UNPACK_FIFO_STATUS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; only rst clears them.
    always_comb begin
        overflow_d  = overflow_q | (line_we & full);
        underflow_d = underflow_q | (rd & empty);
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign occupancy = head_q - base_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_line_unpack_fifo.sv
// Directed bench for line_unpack_fifo; status-port checks follow LINE_UNPACK_FIFO_STATUS_EN.
module tb_line_unpack_fifo;

    logic        pixel_clk = 1'b0;
    logic        rst;
    logic [31:0] line_in;
    logic        line_we;
    logic        full;
    logic        rd;
    logic [7:0]  word_out;
    logic        word_valid;
    logic        last_word;
    logic        empty;
`ifdef LINE_UNPACK_FIFO_STATUS_EN
    logic [2:0]  occupancy;
    logic        overflow;
    logic        underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 pixel_clk = ~pixel_clk;

    line_unpack_fifo #(
        .LINE_WIDTH (32),
        .WORD_WIDTH (8),
        .NUM_LINES  (4)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .line_in    (line_in),
        .line_we    (line_we),
        .full       (full),
        .rd         (rd),
        .word_out   (word_out),
        .word_valid (word_valid),
        .last_word  (last_word),
        .empty      (empty)
`ifdef LINE_UNPACK_FIFO_STATUS_EN
        ,
        .occupancy  (occupancy),
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle before sampling.
    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // Line whose byte i is {h, i}.
    function automatic logic [31:0] mk_line(input logic [3:0] h);
        return {h, 4'd3, h, 4'd2, h, 4'd1, h, 4'd0};
    endfunction

    task automatic check_word(input string tag, input logic [7:0] w, input logic lw);
        check({tag, " valid"}, 32'(word_valid), 32'd1);
        check({tag, " word"}, 32'(word_out), 32'(w));
        check({tag, " last"}, 32'(last_word), 32'(lw));
    endtask

    initial begin
        rst     = 1'b1;
        line_in = '0;
        line_we = 1'b0;
        rd      = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst word_out", 32'(word_out), 32'h0);
        check("rst word_valid", 32'(word_valid), 32'd0);
        check("rst last_word", 32'(last_word), 32'd0);
        check("rst full", 32'(full), 32'd0);
        check("rst empty", 32'(empty), 32'd1);

        // Reads while empty are ignored
        rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("underrd valid", 32'(word_valid), 32'd0);
            check("underrd empty", 32'(empty), 32'd1);
            check("underrd word", 32'(word_out), 32'h0);
        end
        rd = 1'b0;
`ifdef LINE_UNPACK_FIFO_STATUS_EN
        check("underflow sticky", 32'(underflow), 32'd1);
        check("overflow clear", 32'(overflow), 32'd0);
`endif

        // Single line, word order LSB first
        line_in = 32'hDDCCBBAA;
        line_we = 1'b1;
        tick();
        line_we = 1'b0;
        check("one empty", 32'(empty), 32'd0);
        rd = 1'b1;
        tick(); check_word("one w0", 8'hAA, 1'b0);
        tick(); check_word("one w1", 8'hBB, 1'b0);
        tick(); check_word("one w2", 8'hCC, 1'b0);
        tick(); check_word("one w3", 8'hDD, 1'b1);
        check("one empty after", 32'(empty), 32'd1);
        rd = 1'b0;
        tick();
        check("idle valid", 32'(word_valid), 32'd0);
        check("idle last", 32'(last_word), 32'd0);
        check("idle hold", 32'(word_out), 32'hDD);

        // Five writes, no reads: fifth is dropped
        line_we = 1'b1;
        for (int l = 0; l < 5; l++) begin
            line_in = mk_line(4'(l));
            tick();
            check($sformatf("fill%0d full", l), 32'(full), (l >= 3) ? 32'd1 : 32'd0);
        end
        line_we = 1'b0;
`ifdef LINE_UNPACK_FIFO_STATUS_EN
        check("overflow sticky", 32'(overflow), 32'd1);
        check("occupancy full", 32'(occupancy), 32'd4);
`endif
        rd = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick();
            check_word($sformatf("fill rd%0d", n), {4'(n / 4), 4'(n % 4)}, (n % 4) == 3);
        end
        check("fill drained", 32'(empty), 32'd1);
        tick();
        check("fill no 5th", 32'(word_valid), 32'd0);
        rd = 1'b0;

        // Write on the cycle a slot frees is dropped; next cycle accepted
        line_we = 1'b1;
        for (int l = 6; l < 10; l++) begin
            line_in = mk_line(4'(l));
            tick();
        end
        line_we = 1'b0;
        check("race full", 32'(full), 32'd1);
        rd = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        line_we = 1'b1;
        line_in = 32'hDEADBEEF;
        tick();
        check_word("race last", 8'h63, 1'b1);
        check("race freed", 32'(full), 32'd0);
        rd = 1'b0;
        line_in = mk_line(4'hA);
        tick();
        line_we = 1'b0;
        check("race refull", 32'(full), 32'd1);
        rd = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick();
            check_word($sformatf("race rd%0d", n), {4'(7 + n / 4), 4'(n % 4)}, (n % 4) == 3);
        end
        rd = 1'b0;
        check("race drained", 32'(empty), 32'd1);

        // Back-to-back reads across two lines
        line_we = 1'b1;
        line_in = 32'h44332211;
        tick();
        line_in = 32'h88776655;
        tick();
        line_we = 1'b0;
        rd = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            check_word($sformatf("b2b rd%0d", n), 8'(8'h11 * (n + 1)), (n % 4) == 3);
        end
        rd = 1'b0;
        check("b2b empty", 32'(empty), 32'd1);

        // Reset mid-line discards the partial line
        line_we = 1'b1;
        line_in = mk_line(4'hB);
        tick();
        line_we = 1'b0;
        rd = 1'b1;
        tick(); check_word("mid w0", 8'hB0, 1'b0);
        tick(); check_word("mid w1", 8'hB1, 1'b0);
        rd  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid empty", 32'(empty), 32'd1);
        check("mid valid", 32'(word_valid), 32'd0);
        check("mid word", 32'(word_out), 32'h0);
        check("mid full", 32'(full), 32'd0);
`ifdef LINE_UNPACK_FIFO_STATUS_EN
        check("mid underflow clr", 32'(underflow), 32'd0);
        check("mid overflow clr", 32'(overflow), 32'd0);
`endif

        // Same-cycle write and read while empty: read ignored, next read gets word 0
        line_we = 1'b1;
        rd      = 1'b1;
        line_in = mk_line(4'hC);
        tick();
        line_we = 1'b0;
        check("wr+rd valid", 32'(word_valid), 32'd0);
        check("wr+rd empty", 32'(empty), 32'd0);
        tick(); check_word("post rst w0", 8'hC0, 1'b0);
        rd = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
